switch_conditioner: RTL

Conditions the ten raw board switch inputs before they reach the CPU's `Switches[9:0]` port. Each bit passes through a two-flop synchroniser and then a per-bit debounce counter. The block outputs a clean, registered level for every bit and a one-cycle change pulse per bit. A dedicated rising-edge pulse on bit 8 lets the control unit treat that switch as a single-step/handshake input without seeing bounce.

---
 rtl/switch_conditioner_if.sv | 13 +
 rtl/switch_conditioner.sv | 82 ++++++++
 2 files changed

// File: rtl/switch_conditioner_if.sv
// Switch conditioner signal bundle: raw board levels in, debounced levels and pulses out.
interface switch_conditioner_if #(
    parameter int N = 10
);
    logic [N-1:0] RawSwitches;
    logic [N-1:0] Switches;
    logic [N-1:0] Changed;
    logic         Sw8Rise;

    // The board/testbench side drives raw levels; the conditioner drives the clean outputs.
    modport master (output RawSwitches, input Switches, Changed, Sw8Rise);
    modport slave  (input RawSwitches, output Switches, Changed, Sw8Rise);
endinterface

// File: rtl/switch_conditioner.sv
// Two-flop synchroniser plus per-bit debounce counter for the board switches,
// with registered levels, per-bit change pulses and a bit-8 rising-edge pulse.
module switch_conditioner #(
    parameter int N               = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    switch_conditioner_if.slave   bus
);
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_param
        $error("switch_conditioner: DEBOUNCE_CYCLES must be in 1..2^20");
    end

    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  sw_q;
    logic [N-1:0]  ch_q;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  hit;

    // A bit commits when it has mismatched for the full debounce window.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = (s2[i] != sw_q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.RawSwitches;
            s2 <= s1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sw_q <= '0;
            ch_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            ch_q <= hit;
            for (int i = 0; i < N; i++) begin
                if (s2[i] == sw_q[i]) begin
                    cnt[i] <= '0;
                end else if (hit[i]) begin
                    sw_q[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Registered from the same commit term as Changed[8], so the two pulses align.
    if (N >= 9) begin : g_sw8
        logic rise_q;
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                rise_q <= 1'b0;
            end else begin
                rise_q <= hit[8] & s2[8];
            end
        end
        assign bus.Sw8Rise = rise_q;
    end else begin : g_no_sw8
        assign bus.Sw8Rise = 1'b0;
    end

    assign bus.Switches = sw_q;
    assign bus.Changed  = ch_q;
endmodule
